rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Byte-stream boot loader: receives a framed program image over a valid/ready byte interface and writes it into the instruction ROM byte array, starting at address 0.
- Holds the core in reset while loading and releases it only after a frame passes its length and checksum checks.
- This is the hardware write path into the instruction ROM. The simulation bench currently fills the ROM by direct memory writes; this block replaces that mechanism.

Parameters:
- ADDR_BITS, 10, ROM byte-address width; ROM holds 2**ADDR_BITS bytes.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  upstream byte valid
- rx_data  in  8  upstream byte
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid & rx_ready are both high at a rising clk edge
- mem_we  out  1  ROM byte write strobe
- mem_addr  out  ADDR_BITS  ROM byte address
- mem_wdata  out  8  ROM write byte
- core_rst  out  1  reset to the core; high while no valid image is present
- done  out  1  last frame loaded and verified
- error  out  1  last frame rejected

Behaviour:
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, error=0. rx_ready rises the first cycle after rst deasserts.
- Frame format: SYNC, LEN_HI, LEN_LO, LEN payload bytes, CHK.
  - LEN is the 16-bit byte count.
  - CHK is the XOR of all payload bytes.
- FSM states: IDLE, LEN_H, LEN_L, DATA, CHECK, DONE, ERR.
- IDLE: accepted byte == SYNC_BYTE -> LEN_H. Any other byte is discarded with no effect.
- LEN_H: store the high byte -> LEN_L.
- LEN_L: form LEN, then:
  - LEN > 2**ADDR_BITS -> ERR.
  - LEN == 0 -> CHECK.
  - Otherwise clear the byte counter and running XOR -> DATA.
- DATA:
  - Each accepted byte drives mem_we=1, mem_addr=counter, mem_wdata=byte on the cycle after acceptance; the outputs are registered, so latency is 1 cycle.
  - The byte is XORed into the running checksum and the counter increments.
  - After LEN bytes -> CHECK.
  - mem_we is high for exactly one cycle per payload byte.
  - Back-to-back transfers are supported: one byte per cycle, with rx_ready held high.
- CHECK: accepted byte == running XOR -> DONE, otherwise -> ERR. With LEN == 0 the expected CHK is 8'h00.
- DONE: core_rst=0, done=1, error=0.
- ERR: core_rst=1, done=0, error=1. ROM contents are left as partially written.
- Restart from DONE or ERR:
  - An accepted SYNC_BYTE -> LEN_H. core_rst returns to 1 and done/error return to 0 on the next cycle.
  - Other bytes are ignored.
- rx_ready is 1 in every state except the reset cycle.
- A SYNC_BYTE value inside LEN or payload bytes is treated as data. There is no resynchronisation mid-frame.
- rst asserted mid-frame: all state is abandoned and all outputs return to their reset values on the next edge. ROM bytes already written are not cleared.
- Width rules:
  - The byte counter is ADDR_BITS+1 bits, so that LEN == 2**ADDR_BITS is reachable.
  - mem_addr is the counter truncated to ADDR_BITS bits.
  - The LEN comparison is done in 17 bits.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE..ERR).
  - SYNC_BYTE default.
  - Frame field offsets.
- No sub-module is required. One natural helper is rom_loader_ckpt, a running-XOR accumulator with clear/enable; it is optional.

Test Plan:
1. Frame A5 00 04 13 05 A0 00 CHK=B6, rx_valid held high -> mem_we pulses at addrs 0..3 with data 13,05,A0,00; done=1, core_rst=0, error=0 after CHK.
2. Same frame with CHK=B7 -> four ROM writes occur, then error=1, core_rst=1, done=0.
3. Garbage 00 FF 12 before A5 00 01 7F 7F -> the garbage causes no writes; one write of 7F at addr 0; done=1.
4. A5 04 01 (LEN=1025, ADDR_BITS=10) -> ERR immediately after LEN_LO, with no mem_we pulses.
5. rx_valid toggled every other cycle on the frame from test 1 -> same writes and done=1. mem_we occurs only on cycles following a transfer.
6. rst pulsed after 2 payload bytes, then the full frame from test 1 resent -> all outputs at reset values after the rst pulse; final done=1, and all 4 bytes correctly written.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, sync marker, frame layout.
package rom_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN_H = 3'd1,
      S_LEN_L = 3'd2,
      S_DATA  = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Byte offsets within a frame; the checksum follows the LEN payload bytes.
   localparam int OFF_SYNC    = 0;
   localparam int OFF_LEN_HI  = 1;
   localparam int OFF_LEN_LO  = 2;
   localparam int OFF_PAYLOAD = 3;

endpackage

// File: rtl/rom_loader_ckpt.sv
// Running XOR accumulator for the frame checksum; clear wins over enable.
module rom_loader_ckpt (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   // Accumulate payload bytes; restart from zero at each new payload.
   always_ff @(posedge clk) begin
      if (rst)
         acc <= 8'h00;
      else if (clr)
         acc <= 8'h00;
      else if (en)
         acc <= acc ^ din;
   end

endmodule

// File: rtl/rom_loader.sv
// Framed byte-stream boot loader: writes the payload into ROM from address 0
// and releases the core only once length and checksum have both checked out.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int         ADDR_BITS = 10,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 core_rst,
   output logic                 done,
   output logic                 error
);

   // Largest legal LEN: exactly fills the ROM.
   localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_BITS;

   state_t               state, state_nx;
   logic [7:0]           len_hi;
   logic [15:0]          len;
   logic [ADDR_BITS:0]   count;   // one extra bit so a full ROM count is representable
   logic [7:0]           chk;
   logic                 xfer;
   logic [16:0]          len_rx;
   logic [16:0]          count_inc;
   logic                 is_sync;

   assign xfer      = rx_valid & rx_ready;
   assign is_sync   = (rx_data == SYNC_BYTE);
   assign len_rx    = {1'b0, len_hi, rx_data};
   assign count_inc = 17'(count) + 17'd1;

   rom_loader_ckpt u_ckpt (
      .clk (clk),
      .rst (rst),
      .clr (xfer && (state == S_LEN_L)),
      .en  (xfer && (state == S_DATA)),
      .din (rx_data),
      .acc (chk)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; core reset and status flags decode from the current state.
   always_comb begin
      state_nx = state;
      core_rst = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         S_IDLE:  if (xfer && is_sync) state_nx = S_LEN_H;
         S_LEN_H: if (xfer) state_nx = S_LEN_L;
         S_LEN_L: begin
            if (xfer) begin
               if (len_rx > MAX_LEN)
                  state_nx = S_ERR;
               else if (len_rx == 17'd0)
                  state_nx = S_CHECK;
               else
                  state_nx = S_DATA;
            end
         end
         S_DATA:  if (xfer && (count_inc == {1'b0, len})) state_nx = S_CHECK;
         S_CHECK: if (xfer) state_nx = (rx_data == chk) ? S_DONE : S_ERR;
         S_DONE: begin
            core_rst = 1'b0;
            done     = 1'b1;
            if (xfer && is_sync) state_nx = S_LEN_H;
         end
         S_ERR: begin
            error = 1'b1;
            if (xfer && is_sync) state_nx = S_LEN_H;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Length capture, payload counter, registered ROM write port and ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ready  <= 1'b0;
         len_hi    <= 8'h00;
         len       <= 16'h0000;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
      end else begin
         rx_ready <= 1'b1;
         mem_we   <= xfer && (state == S_DATA);
         if (xfer && (state == S_LEN_H))
            len_hi <= rx_data;
         if (xfer && (state == S_LEN_L)) begin
            len   <= len_rx[15:0];
            count <= '0;
         end
         if (xfer && (state == S_DATA)) begin
            count     <= count + (ADDR_BITS+1)'(1);
            mem_addr  <= count[ADDR_BITS-1:0];
            mem_wdata <= rx_data;
         end
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed and random frames against a frame-parsing model.
module tb_rom_loader;
   import rom_loader_pkg::*;

   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;

   typedef logic [7:0] byte_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_ready, mem_we, core_rst, done, error;
   logic [AB-1:0] mem_addr;
   logic [7:0]    mem_wdata;

   int    checks = 0;
   int    errors = 0;
   int    exp_q[$];          // expected writes, addr*256 + data
   int    exp_status;        // 0 incomplete, 1 done, 2 error
   byte_t rom_dut[DEPTH];
   logic  acc_d = 1'b0;
   byte_t s[$];

   rom_loader #(.ADDR_BITS(AB)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_rst(core_rst), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Remember whether a byte transferred at each edge.
   always @(posedge clk) acc_d <= rx_valid & rx_ready;

   // Every write must follow a transfer and match the next expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         checks++;
         assert (acc_d === 1'b1) else begin
            errors++;
            $error("FAIL we_without_xfer addr=%0d", mem_addr);
         end
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL extra_write got=%0h exp=none", {mem_addr, mem_wdata});
         end
         if (exp_q.size() > 0) chk("write", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
         rom_dut[mem_addr] = mem_wdata;
      end
   end

   // Parse one frame from the byte list: skip to SYNC, read LEN, payload, CHK.
   task automatic model(input byte_t f[$]);
      int i, len;
      byte_t x;
      exp_status = 0;
      i = 0;
      while (i < f.size() && f[i] != SYNC_BYTE_DEF) i++;
      if (i + OFF_LEN_LO >= f.size()) return;
      len = int'(f[i+OFF_LEN_HI]) * 256 + int'(f[i+OFF_LEN_LO]);
      i = i + OFF_PAYLOAD;
      if (len > DEPTH) begin exp_status = 2; return; end
      x = 8'h00;
      for (int k = 0; k < len && i + k < f.size(); k++) begin
         exp_q.push_back(k * 256 + int'(f[i+k]));
         x = x ^ f[i+k];
      end
      if (i + len >= f.size()) return;
      exp_status = (f[i+len] == x) ? 1 : 2;
   endtask

   // Drive bytes; gap 0 back-to-back, 1 idle cycle between bytes, 2 random idles.
   task automatic send(input byte_t f[$], input int gap);
      int t;
      for (int i = 0; i < f.size(); i++) begin
         rx_valid = 1'b1;
         rx_data  = f[i];
         t = 0;
         while (rx_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
         checks++;
         assert (t < 20) else begin errors++; $error("FAIL ready_timeout got=0 exp=1"); end
         @(posedge clk);
         @(negedge clk);
         if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            rx_data  = byte_t'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_done"},  32'(done),     32'(exp_status == 1));
      chk({tag, "_error"}, 32'(error),    32'(exp_status == 2));
      chk({tag, "_crst"},  32'(core_rst), 32'(exp_status != 1));
      chk({tag, "_pend"},  32'(exp_q.size()), 32'd0);
   endtask

   task automatic run(input byte_t f[$], input int gap, input string tag);
      model(f);
      send(f, gap);
      check_status(tag);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, 32'(rx_ready),  32'd0);
      chk({tag, "_we"},    32'(mem_we),    32'd0);
      chk({tag, "_addr"},  32'(mem_addr),  32'd0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_crst"},  32'(core_rst),  32'd1);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_error"}, 32'(error),     32'd0);
   endtask

   initial begin
      int len, ng;
      byte_t x, g;

      repeat (2) @(negedge clk);
      check_reset("rst");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(rx_ready), 32'd1);

      // 1: good frame, back-to-back
      s = '{8'hA5, 8'h00, 8'h04, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
      run(s, 0, "t1");
      // 2: bad checksum
      s = '{8'hA5, 8'h00, 8'h04, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
      run(s, 0, "t2");
      // 3: garbage before sync
      s = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h01, 8'h7F, 8'h7F};
      run(s, 0, "t3");
      // 4: oversize LEN rejected right after LEN_LO
      s = '{8'hA5, 8'h04, 8'h01};
      run(s, 0, "t4");
      // 5: toggled valid
      s = '{8'hA5, 8'h00, 8'h04, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
      run(s, 1, "t5");

      // restart from DONE drops done and reasserts core reset
      s = '{8'hA5, 8'h00, 8'h00, 8'h00};
      model(s);
      send('{8'hA5}, 0);
      chk("restart_crst", 32'(core_rst), 32'd1);
      chk("restart_done", 32'(done), 32'd0);
      send('{8'h00, 8'h00, 8'h00}, 0);
      check_status("len0");
      // LEN 0 with nonzero CHK
      run('{8'hA5, 8'h00, 8'h00, 8'h01}, 0, "len0bad");
      // SYNC value inside payload is data
      run('{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h00}, 2, "syncdata");

      // 6: reset mid-frame, then resend
      model('{8'hA5, 8'h00, 8'h04, 8'h13, 8'h05});
      send('{8'hA5, 8'h00, 8'h04, 8'h13, 8'h05}, 0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("midrst");
      chk("midrst_pend", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;
      s = '{8'hA5, 8'h00, 8'h04, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
      run(s, 0, "t6");
      chk("t6_rom0", 32'(rom_dut[0]), 32'h13);
      chk("t6_rom1", 32'(rom_dut[1]), 32'h05);
      chk("t6_rom2", 32'(rom_dut[2]), 32'hA0);
      chk("t6_rom3", 32'(rom_dut[3]), 32'h00);

      // full-ROM frame, LEN == 2**ADDR_BITS
      s = '{8'hA5, 8'h04, 8'h00};
      x = 8'h00;
      for (int k = 0; k < DEPTH; k++) begin
         g = byte_t'($urandom);
         s.push_back(g);
         x = x ^ g;
      end
      s.push_back(x);
      run(s, 0, "full");
      chk("full_last", 32'(rom_dut[DEPTH-1]), 32'(s[OFF_PAYLOAD+DEPTH-1]));

      // random frames
      for (int n = 0; n < 12; n++) begin
         s = {};
         ng = $urandom_range(0, 3);
         for (int k = 0; k < ng; k++) begin
            g = byte_t'($urandom);
            if (g == SYNC_BYTE_DEF) g = 8'h00;
            s.push_back(g);
         end
         len = $urandom_range(0, 24);
         s.push_back(SYNC_BYTE_DEF);
         s.push_back(8'h00);
         s.push_back(byte_t'(len));
         x = 8'h00;
         for (int k = 0; k < len; k++) begin
            g = byte_t'($urandom);
            s.push_back(g);
            x = x ^ g;
         end
         if ($urandom_range(0, 2) == 0) x = x ^ byte_t'($urandom_range(1, 255));
         s.push_back(x);
         run(s, $urandom_range(0, 2), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
